main_memory_arbiter: RTL

//  Shares the single-port main memory (512 x 32 DATA_RAM) between the IF-stage fetch port and the MEM-stage data port.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_if.sv | 44 ++++
 rtl/mem_arb_priority.sv | 32 +++
 rtl/main_memory_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the main-memory arbiter: owner, FSM states, default widths.
package mem_arb_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of fetch port, data port, memory port and idle flag around the arbiter.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              idle;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, idle
    );

    // Pipeline stages plus memory side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, idle
    );

endinterface

// File: rtl/mem_arb_priority.sv
// Winner select between fetch and data ports; data wins unless fetch has starved STARVE_MAX times.
module mem_arb_priority #(
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic arb_en,
    input  logic if_req,
    input  logic dm_req,
    output logic if_gnt,
    output logic dm_gnt
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_cnt_reg;
    logic          force_if;

    assign force_if = (starve_cnt_reg == CW'(STARVE_MAX));
    assign dm_gnt   = arb_en && dm_req && !(if_req && force_if);
    assign if_gnt   = arb_en && if_req && !dm_gnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_cnt_reg <= '0;
        end else if (if_gnt) begin
            starve_cnt_reg <= '0;
        end else if (if_req && dm_gnt && !force_if) begin
            starve_cnt_reg <= starve_cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/main_memory_arbiter.sv
// Single-outstanding, fixed-latency arbiter between IF fetch and MEM data ports.
// Optional MEM_ARB_PERF_EN adds grant and conflict counters.
module main_memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    mem_arb_if.slave    bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_if_cnt,
    output logic [31:0] perf_dm_cnt,
    output logic [31:0] perf_conflict_cnt
`endif
);
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    logic [1:0] state_reg, state_next;
    logic [2:0] lat_reg, lat_next;
    owner_t     owner_reg, owner_next;
    logic       we_reg, we_next;

    logic arb_en, resp_en, if_gnt, dm_gnt;

    // Grants and response pulses are suppressed while reset is held
    assign arb_en  = (state_reg == ST_IDLE) && !RESET;
    assign resp_en = (state_reg == ST_RESP) && !RESET;

    mem_arb_priority #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .CLK    (CLK),
        .RESET  (RESET),
        .arb_en (arb_en),
        .if_req (bus.if_req),
        .dm_req (bus.dm_req),
        .if_gnt (if_gnt),
        .dm_gnt (dm_gnt)
    );

    always_comb begin
        state_next = state_reg;
        lat_next   = lat_reg;
        owner_next = owner_reg;
        we_next    = we_reg;
        case (state_reg)
            ST_IDLE: begin
                if (if_gnt || dm_gnt) begin
                    owner_next = dm_gnt ? OWN_DM : OWN_IF;
                    we_next    = dm_gnt && bus.dm_we;
                    lat_next   = LAT_INIT;
                    state_next = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                lat_next = lat_reg - 3'd1;
                if (lat_reg == 3'd2) state_next = ST_RESP;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
            lat_reg   <= '0;
            owner_reg <= OWN_IF;
            we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            lat_reg   <= lat_next;
            owner_reg <= owner_next;
            we_reg    <= we_next;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.mem_en    = if_gnt || dm_gnt;
    assign bus.mem_we    = dm_gnt && bus.dm_we;
    assign bus.mem_addr  = dm_gnt ? bus.dm_addr : (if_gnt ? bus.if_addr : '0);
    assign bus.mem_wdata = (dm_gnt && bus.dm_we) ? bus.dm_wdata : '0;

    assign bus.if_rvalid = resp_en && (owner_reg == OWN_IF);
    assign bus.dm_rvalid = resp_en && (owner_reg == OWN_DM);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    // Write completions return zero rather than whatever the memory drives
    assign bus.dm_rdata  = (bus.dm_rvalid && !we_reg) ? bus.mem_rdata : '0;

    assign bus.idle = RESET || ((state_reg == ST_IDLE) && !if_gnt && !dm_gnt);

`ifdef MEM_ARB_PERF_EN
    logic conflict;
    assign conflict = (bus.if_req && !if_gnt) || (bus.dm_req && !dm_gnt);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            perf_if_cnt       <= '0;
            perf_dm_cnt       <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (if_gnt)   perf_if_cnt       <= perf_if_cnt + 32'd1;
            if (dm_gnt)   perf_dm_cnt       <= perf_dm_cnt + 32'd1;
            if (conflict) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
